// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types and constants for board_io_ctrl
package board_io_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } rst_state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/board_debounce.sv
// rtl/board_debounce.sv - one-channel synchroniser plus stable-count debouncer
module board_debounce
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000
)
(
   input  logic i_clk,
   input  logic i_arst,
   input  logic i_raw,
   output logic o_stable
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_stable;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign o_stable = r_stable;

   // Any sample that agrees with the stable value restarts the count.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         if (w_synced == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= w_synced;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - reset sequencer, switch/button debounce and button irq
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int NSW             = 16,
   parameter int NBTN            = 5,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int RST_HOLD_CYCLES = 16
)
(
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            pll_locked_i,
   input  logic [NSW-1:0]  sw_i,
   input  logic [NBTN-1:0] btn_i,
   input  logic [NBTN-1:0] btn_mask_i,
   input  logic            irq_ack_i,
   output logic            rst_o,
   output logic [NSW-1:0]  sw_o,
   output logic [NBTN-1:0] btn_o,
   output logic [NBTN-1:0] btn_rise_o,
   output logic            irq_o
);

   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic                   w_lock;
   rst_state_t             r_state;
   logic [HW-1:0]          r_hold_cnt;
   logic                   r_rst;
   logic [NBTN-1:0]        r_btn_d;
   logic [NBTN-1:0]        r_rise;
   logic                   r_irq;
   logic [NSW-1:0]         w_sw;
   logic [NBTN-1:0]        w_btn;

   assign w_lock = r_lock_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_lock_sync <= '0;
      end else begin
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state    <= WAIT_LOCK;
         r_hold_cnt <= '0;
         r_rst      <= 1'b1;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               if (w_lock) begin
                  r_state    <= HOLD;
                  r_hold_cnt <= '0;
               end
            end
            HOLD: begin
               if (!w_lock) begin
                  r_state <= WAIT_LOCK;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  r_state <= RUN;
                  r_rst   <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            RUN: begin
               if (!w_lock) begin
                  r_state <= WAIT_LOCK;
                  r_rst   <= 1'b1;
               end
            end
            default: begin
               r_state <= WAIT_LOCK;
               r_rst   <= 1'b1;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
      board_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .i_clk    (clk_i),
         .i_arst   (arst_i),
         .i_raw    (sw_i[gi]),
         .o_stable (w_sw[gi])
      );
   end

   for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      board_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .i_clk    (clk_i),
         .i_arst   (arst_i),
         .i_raw    (btn_i[gi]),
         .o_stable (w_btn[gi])
      );
   end

   // r_btn_d tracks btn_o even in reset so a button held across release gives no rise.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_btn_d <= '0;
         r_rise  <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_btn_d <= w_btn;
         if (r_rst) begin
            r_rise <= '0;
            r_irq  <= 1'b0;
         end else begin
            r_rise <= w_btn & ~r_btn_d;
            if (|(r_rise & btn_mask_i)) begin
               r_irq <= 1'b1;
            end else if (irq_ack_i) begin
               r_irq <= 1'b0;
            end
         end
      end
   end

   assign rst_o      = r_rst;
   assign sw_o       = w_sw;
   assign btn_o      = w_btn;
   assign btn_rise_o = r_rise;
   assign irq_o      = r_irq;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - self-checking bench for board_io_ctrl
module tb_board_io_ctrl;

   localparam int NSW  = 4;
   localparam int NBTN = 2;
   localparam int DB   = 4;
   localparam int HOLD = 8;
   localparam int NT   = 400;

   logic            clk;
   logic            arst;
   logic            lock;
   logic [NSW-1:0]  sw;
   logic [NBTN-1:0] btn;
   logic [NBTN-1:0] mask;
   logic            ack;
   logic            rst_o;
   logic [NSW-1:0]  sw_o;
   logic [NBTN-1:0] btn_o;
   logic [NBTN-1:0] rise_o;
   logic            irq_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [NSW-1:0]  sw_h   [-8:NT];
   logic [NBTN-1:0] btn_h  [-8:NT];
   logic [NBTN-1:0] mask_h [-8:NT];
   logic            ack_h  [-8:NT];
   logic [NSW-1:0]  sw_e   [-8:NT];
   logic [NBTN-1:0] btn_e  [-8:NT];
   logic [NBTN-1:0] rise_e [-8:NT];
   logic            irq_e  [-8:NT];

   board_io_ctrl #(
      .NSW(NSW), .NBTN(NBTN), .DEBOUNCE_CYCLES(DB), .RST_HOLD_CYCLES(HOLD)
   ) dut (
      .clk_i        (clk),
      .arst_i       (arst),
      .pll_locked_i (lock),
      .sw_i         (sw),
      .btn_i        (btn),
      .btn_mask_i   (mask),
      .irq_ack_i    (ack),
      .rst_o        (rst_o),
      .sw_o         (sw_o),
      .btn_o        (btn_o),
      .btn_rise_o   (rise_o),
      .irq_o        (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst = 1'b1; lock = 1'b0; sw = '1; btn = '1; mask = '1; ack = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_rst_o got %b want 1", rst_o); end
      n_tests++;
      if (sw_o !== '0) begin n_fail++; $display("FAIL reset_sw_o got %h want 0", sw_o); end
      n_tests++;
      if (btn_o !== '0) begin n_fail++; $display("FAIL reset_btn_o got %h want 0", btn_o); end
      n_tests++;
      if (rise_o !== '0 || irq_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_rise_irq got %b/%b want 0/0", rise_o, irq_o);
      end
      sw = '0; btn = '0; mask = '0;
   endtask

   task automatic test_release();
      int n;
      lock = 1'b1;
      repeat (3) tick();
      arst = 1'b0;
      n = 0;
      while (rst_o === 1'b1 && n < 40) begin tick(); n++; end
      n_tests++;
      if (n != 2 + 1 + HOLD) begin
         n_fail++; $display("FAIL release_latency got %0d cycles want %0d", n, 2 + 1 + HOLD);
      end
   endtask

   task automatic test_lock_loss();
      int n;
      lock = 1'b0;
      n = 0;
      while (rst_o !== 1'b1 && n < 20) begin tick(); n++; end
      n_tests++;
      if (n != 3) begin n_fail++; $display("FAIL lock_drop_latency got %0d want 3", n); end
      repeat (5) tick();
      lock = 1'b1;
      n = 0;
      while (rst_o === 1'b1 && n < 40) begin tick(); n++; end
      n_tests++;
      if (n != 2 + 1 + HOLD) begin
         n_fail++; $display("FAIL lock_return_latency got %0d want %0d", n, 2 + 1 + HOLD);
      end
   endtask

   task automatic test_glitch();
      int bad;
      logic [NSW-1:0] s5, s6;
      sw = 4'b0100;
      repeat (3) tick();
      sw = 4'b0000;
      bad = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (sw_o !== 4'b0000) bad++; end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL glitch_filtered got %0d bad cycles want 0", bad); end
      sw = 4'b0100;
      s5 = 'x; s6 = 'x;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 5) s5 = sw_o;
         if (i == 6) s6 = sw_o;
      end
      n_tests++;
      if (s5 !== 4'b0000) begin n_fail++; $display("FAIL sw_early got %b want 0000", s5); end
      n_tests++;
      if (s6 !== 4'b0100) begin n_fail++; $display("FAIL sw_edge_latency got %b want 0100", s6); end
   endtask

   task automatic test_btn_irq();
      int pulses, first, irq_any;
      logic irq8, irq7;
      ack = 1'b1; tick(); ack = 1'b0;
      mask = 2'b01; btn = 2'b01;
      pulses = 0; first = -1; irq7 = 1'bx; irq8 = 1'bx;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (rise_o[0] === 1'b1) begin pulses++; if (first < 0) first = i; end
         if (i == 7) irq7 = irq_o;
         if (i == 8) irq8 = irq_o;
      end
      n_tests++;
      if (pulses != 1 || first != 7) begin
         n_fail++; $display("FAIL btn0_rise got %0d pulses at %0d want 1 at 7", pulses, first);
      end
      n_tests++;
      if (irq7 !== 1'b0 || irq8 !== 1'b1) begin
         n_fail++; $display("FAIL btn0_irq got %b%b want 01", irq7, irq8);
      end
      ack = 1'b1; tick(); ack = 1'b0;
      n_tests++;
      if (irq_o !== 1'b0) begin n_fail++; $display("FAIL ack_clear got %b want 0", irq_o); end
      btn = 2'b11;
      pulses = 0; irq_any = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (rise_o[1] === 1'b1) pulses++;
         if (irq_o !== 1'b0) irq_any++;
      end
      n_tests++;
      if (pulses != 1 || irq_any != 0) begin
         n_fail++; $display("FAIL btn1_unmasked got %0d pulses irq %0d want 1 pulse irq 0", pulses, irq_any);
      end
      btn = 2'b00;
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin tick(); if (rise_o !== 2'b00) pulses++; end
      n_tests++;
      if (pulses != 0 || btn_o !== 2'b00) begin
         n_fail++; $display("FAIL btn_fall got %0d pulses btn_o %b want 0 and 00", pulses, btn_o);
      end
   endtask

   task automatic test_ack_collision();
      mask = 2'b11; btn = 2'b10;
      repeat (10) tick();
      n_tests++;
      if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_preset got %b want 1", irq_o); end
      btn = 2'b11;
      repeat (7) tick();
      n_tests++;
      if (rise_o !== 2'b01) begin n_fail++; $display("FAIL collision_rise got %b want 01", rise_o); end
      ack = 1'b1;
      tick();
      n_tests++;
      if (irq_o !== 1'b1) begin n_fail++; $display("FAIL ack_collision got %b want 1", irq_o); end
      tick();
      n_tests++;
      if (irq_o !== 1'b0) begin n_fail++; $display("FAIL ack_alone got %b want 0", irq_o); end
      ack = 1'b0; btn = 2'b00; mask = 2'b00;
      repeat (10) tick();
   endtask

   task automatic test_arst_mid();
      int n;
      logic [NSW-1:0] s5, s6;
      sw = 4'b0101;
      repeat (4) tick();
      arst = 1'b1;
      #1;
      n_tests++;
      if ({rst_o, sw_o, btn_o, rise_o, irq_o} !== {1'b1, 4'b0, 2'b0, 2'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL arst_mid got rst %b sw %b btn %b rise %b irq %b want 1/0000/00/00/0",
                  rst_o, sw_o, btn_o, rise_o, irq_o);
      end
      tick();
      arst = 1'b0;
      n = 0; s5 = 'x; s6 = 'x;
      while ((rst_o === 1'b1 || n < 6) && n < 40) begin
         tick(); n++;
         if (n == 5) s5 = sw_o;
         if (n == 6) s6 = sw_o;
      end
      n_tests++;
      if (s5 !== 4'b0000 || s6 !== 4'b0101) begin
         n_fail++; $display("FAIL arst_restart_debounce got %b,%b want 0000,0101", s5, s6);
      end
      n_tests++;
      if (n != 2 + 1 + HOLD) begin n_fail++; $display("FAIL arst_restart_rst got %0d want %0d", n, 2 + 1 + HOLD); end
   endtask

   task automatic test_random();
      int n;
      logic [NSW-1:0]  nsw;
      logic [NBTN-1:0] nbtn;
      logic            diff;
      sw = '0; btn = '0; mask = '0; ack = 1'b0; lock = 1'b1;
      arst = 1'b1; tick(); arst = 1'b0;
      n = 0;
      while (rst_o === 1'b1 && n < 40) begin tick(); n++; end
      n_tests++;
      if (rst_o !== 1'b0) begin n_fail++; $display("FAIL random_setup rst_o got %b want 0", rst_o); end
      repeat (10) tick();
      for (int t = -8; t <= 0; t++) begin
         sw_h[t] = '0; btn_h[t] = '0; mask_h[t] = '0; ack_h[t] = 1'b0;
         sw_e[t] = '0; btn_e[t] = '0; rise_e[t] = '0; irq_e[t] = 1'b0;
      end
      for (int t = 1; t <= NT; t++) begin
         nsw = sw_h[t-1]; nbtn = btn_h[t-1];
         for (int c = 0; c < NSW; c++) if ($urandom_range(0, 5) == 0) nsw[c] = ~nsw[c];
         for (int c = 0; c < NBTN; c++) if ($urandom_range(0, 5) == 0) nbtn[c] = ~nbtn[c];
         sw_h[t] = nsw; btn_h[t] = nbtn;
         mask_h[t] = 2'($urandom_range(0, 3));
         ack_h[t] = ($urandom_range(0, 3) == 0);
         sw = nsw; btn = nbtn; mask = mask_h[t]; ack = ack_h[t];
         tick();
         // An output flips once the input seen two cycles late has differed for DB straight cycles.
         for (int c = 0; c < NSW; c++) begin
            diff = 1'b1;
            for (int k = 0; k < DB; k++) if (sw_h[t-2-k][c] == sw_e[t-1][c]) diff = 1'b0;
            sw_e[t][c] = diff ? ~sw_e[t-1][c] : sw_e[t-1][c];
         end
         for (int c = 0; c < NBTN; c++) begin
            diff = 1'b1;
            for (int k = 0; k < DB; k++) if (btn_h[t-2-k][c] == btn_e[t-1][c]) diff = 1'b0;
            btn_e[t][c] = diff ? ~btn_e[t-1][c] : btn_e[t-1][c];
         end
         rise_e[t] = btn_e[t-1] & ~btn_e[t-2];
         irq_e[t] = (|(rise_e[t-1] & mask_h[t])) ? 1'b1 : (ack_h[t] ? 1'b0 : irq_e[t-1]);
         n_tests++;
         if ({sw_o, btn_o, rise_o, irq_o} !== {sw_e[t], btn_e[t], rise_e[t], irq_e[t]}) begin
            n_fail++;
            $display("FAIL random_t%0d got sw %b btn %b rise %b irq %b want sw %b btn %b rise %b irq %b",
                     t, sw_o, btn_o, rise_o, irq_o, sw_e[t], btn_e[t], rise_e[t], irq_e[t]);
         end
      end
      sw = '0; btn = '0; mask = '0; ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_release();
      test_lock_loss();
      test_glitch();
      test_btn_irq();
      test_ack_collision();
      test_arst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
